// File: rtl/mag_comp_seq_pkg.sv
// -----------------------------------------------------------------------------
// mag_comp_pkg
//   Shared types and sizing helpers for the sequential magnitude comparator.
//   state_t   : comparator FSM states (IDLE, CMP)
//   clog2     : ceiling log2 used to size the chunk index
//   idx_width : chunk index width, at least one bit even when there is one chunk
// -----------------------------------------------------------------------------
package mag_comp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CMP  = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int idx_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/mag_comp_seq_chunk_cmp.sv
// -----------------------------------------------------------------------------
// chunk_cmp
//   Combinational unsigned compare of one CHUNK-bit slice; the generalised form
//   of the old 4-bit eq/lt comparator.
//   a, b : slice operands (unsigned)
//   eq   : a == b
//   lt   : a <  b
// -----------------------------------------------------------------------------
module chunk_cmp #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             eq,
   output logic             lt
);

   assign eq = (a == b);
   assign lt = (a < b);

endmodule

// File: rtl/mag_comp_seq.sv
// -----------------------------------------------------------------------------
// mag_comp_seq
//   Multi-cycle magnitude comparator. Compares two WIDTH-bit operands CHUNK
//   bits per cycle, most significant chunk first, signed or unsigned, with an
//   optional early exit on the first differing chunk.
//
//   Handshake: start is sampled only while busy = 0; the edge that samples it
//   latches a, b and signed_mode and raises busy. done pulses for one cycle on
//   the finishing edge, and eq/lt/gt are valid from then until the next done
//   or reset. abort in CMP returns to IDLE with no done and results untouched.
//
//   Ports
//     clk, rst_n    : clock, asynchronous active-low reset
//     start         : compare request
//     signed_mode   : 1 = two's-complement compare (latched with start)
//     abort         : cancel an in-flight compare
//     a, b          : operands (latched with start)
//     busy          : compare in progress
//     done          : one-cycle completion pulse
//     eq, lt, gt    : registered compare result
// -----------------------------------------------------------------------------
module mag_comp_seq
   import mag_comp_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int CHUNK      = 4,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             lt,
   output logic             gt
);

   localparam int               N        = WIDTH / CHUNK;
   localparam int               IDX_W    = idx_width(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [WIDTH-1:0] MSB_BIT  = WIDTH'(1) << (WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IDX_W-1:0] idx;
   logic             decided;
   logic             dec_lt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [CHUNK-1:0] chunk_a;
   logic [CHUNK-1:0] chunk_b;
   logic             c_eq;
   logic             c_lt;
   logic             diff;
   logic             is_last;
   logic             finish;
   logic             res_diff;
   logic             res_lt;
   logic             accept;

   // Shifting the current chunk up to the MSB end keeps the select a constant
   // part-select and lets one chunk_cmp serve every chunk.
   assign a_sh    = a_q << (idx * CHUNK);
   assign b_sh    = b_q << (idx * CHUNK);
   assign chunk_a = a_sh[WIDTH-1 -: CHUNK];
   assign chunk_b = b_sh[WIDTH-1 -: CHUNK];

   chunk_cmp #(
      .CHUNK (CHUNK)
   ) u_chunk_cmp (
      .a  (chunk_a),
      .b  (chunk_b),
      .eq (c_eq),
      .lt (c_lt)
   );

   assign diff    = ~c_eq;
   assign is_last = (idx == LAST_IDX);
   assign accept  = (state == IDLE) && start;

   // Once a chunk has differed its verdict is frozen; later chunks are ignored.
   assign res_diff = decided | diff;
   assign res_lt   = decided ? dec_lt : c_lt;

   assign finish = (state == CMP) && (is_last || ((EARLY_EXIT != 0) && diff));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   // abort has priority over finish so a cancelled compare never reports.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = CMP;
            end
         end
         CMP: begin
            if (abort || finish) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = 1'b0;
      if (state == CMP) begin
         busy = 1'b1;
      end
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         idx     <= '0;
         decided <= 1'b0;
         dec_lt  <= 1'b0;
         done    <= 1'b0;
         eq      <= 1'b0;
         lt      <= 1'b0;
         gt      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            // Flipping the sign bit of both operands maps two's-complement
            // order onto unsigned order, so the chunk compare stays unsigned.
            a_q     <= signed_mode ? (a ^ MSB_BIT) : a;
            b_q     <= signed_mode ? (b ^ MSB_BIT) : b;
            idx     <= '0;
            decided <= 1'b0;
            dec_lt  <= 1'b0;
         end else if ((state == CMP) && !abort) begin
            idx <= idx + 1'b1;
            if (!decided && diff) begin
               decided <= 1'b1;
               dec_lt  <= c_lt;
            end
            if (finish) begin
               done <= 1'b1;
               eq   <= ~res_diff;
               lt   <= res_diff & res_lt;
               gt   <= res_diff & ~res_lt;
            end
         end
      end
   end

endmodule

// File: tb/tb_mag_comp_seq.sv
// -----------------------------------------------------------------------------
// tb_mag_comp_seq
//   Eight comparator instances share one operand bus:
//     u0 16/4 early-exit, u1 16/4 full-scan,
//     u2..u7 32-bit with CHUNK 1, 8, 32, each with early exit on and off.
//   The 16-bit instances see the low half of the operand bus. Expected results
//   and latencies come from an integer reference model and are queued at
//   launch, then popped when each instance reports done.
// -----------------------------------------------------------------------------
module tb_mag_comp_seq;

  function automatic int cfg_w(input int i);
    return (i < 2) ? 16 : 32;
  endfunction

  function automatic int cfg_c(input int i);
    int c;
    case (i)
      0, 1:    c = 4;
      2, 3:    c = 1;
      4, 5:    c = 8;
      default: c = 32;
    endcase
    return c;
  endfunction

  function automatic int cfg_e(input int i);
    return ((i % 2) == 0) ? 1 : 0;
  endfunction

  logic        clk;
  logic        rst_n;
  logic [31:0] a_bus;
  logic [31:0] b_bus;
  logic        sm_bus;
  logic [7:0]  start_v;
  logic [7:0]  abort_v;
  logic [7:0]  busy_v;
  logic [7:0]  done_v;
  logic [7:0]  eq_v;
  logic [7:0]  lt_v;
  logic [7:0]  gt_v;

  for (genvar gi = 0; gi < 8; gi++) begin : g_dut
    localparam int GW = cfg_w(gi);
    mag_comp_seq #(
      .WIDTH      (GW),
      .CHUNK      (cfg_c(gi)),
      .EARLY_EXIT (cfg_e(gi))
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_v[gi]),
      .signed_mode (sm_bus),
      .abort       (abort_v[gi]),
      .a           (a_bus[GW-1:0]),
      .b           (b_bus[GW-1:0]),
      .busy        (busy_v[gi]),
      .done        (done_v[gi]),
      .eq          (eq_v[gi]),
      .lt          (lt_v[gi]),
      .gt          (gt_v[gi])
    );
  end

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  // entry = {instance[3:0], eq, lt, gt, latency[7:0]}
  logic [14:0] exp_q[$];
  logic [2:0]  last_res [8];
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word integer compare; latency from the top differing bit.
  function automatic logic [10:0] ref_model(input int w, input int c, input int ee,
                                            input logic [31:0] ra, input logic [31:0] rb,
                                            input logic sm);
    logic [31:0] ma, mb, x;
    longint      sa, sb;
    int          lat, p;
    logic        r_eq, r_lt, r_gt;
    ma = (w == 32) ? ra : (ra & ((32'd1 << w) - 32'd1));
    mb = (w == 32) ? rb : (rb & ((32'd1 << w) - 32'd1));
    sa = longint'(ma);
    sb = longint'(mb);
    if (sm) begin
      if (ma[w-1]) sa = sa - (longint'(1) << w);
      if (mb[w-1]) sb = sb - (longint'(1) << w);
    end
    r_eq = (sa == sb);
    r_lt = (sa < sb);
    r_gt = (sa > sb);
    lat  = w / c;
    if ((ee != 0) && !r_eq) begin
      x = ma ^ mb;
      p = 0;
      for (int i = 0; i < w; i++) begin
        if (x[i]) p = i;
      end
      lat = (w - 1 - p) / c + 1;
    end
    return {r_eq, r_lt, r_gt, 8'(lat)};
  endfunction

  // Drive a request to the masked instances and queue their expectations.
  // Returns #1 after the start edge; operands are then scrambled.
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb,
                        input logic tsm, input logic [7:0] mask);
    logic [10:0] r;
    a_bus   = ta;
    b_bus   = tb;
    sm_bus  = tsm;
    start_v = mask;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        r = ref_model(cfg_w(i), cfg_c(i), cfg_e(i), ta, tb, tsm);
        exp_q.push_back({4'(i), r});
      end
    end
    @(posedge clk);
    #1;
    start_v = '0;
    a_bus   = $urandom;
    b_bus   = $urandom;
    sm_bus  = 1'($urandom_range(0, 1));
  endtask

  // Watch the masked instances until all report done (bounded), then compare.
  // hold > 0 keeps start high with a = 0 for that many further edges.
  // Returns in the done cycle so a following launch lands back-to-back.
  task automatic collect(input logic [7:0] mask, input int hold);
    int          lat  [8];
    int          bcnt [8];
    logic [7:0]  seen;
    logic [14:0] e;
    int          j;
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      lat[i]  = 0;
      bcnt[i] = 0;
    end
    j = 0;
    while (((seen & mask) != mask) && (j < 80)) begin
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) begin
          if (busy_v[i] && !seen[i]) bcnt[i]++;
          if (done_v[i] && !seen[i]) begin
            seen[i] = 1'b1;
            lat[i]  = j;
          end
        end
      end
      if ((seen & mask) != mask) begin
        if (j < hold) begin
          start_v = mask;
          a_bus   = '0;
        end else begin
          start_v = '0;
        end
        @(posedge clk);
        #1;
        j++;
      end
    end
    start_v = '0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        e = exp_q.pop_front();
        check($sformatf("done_seen_u%0d", i), 32'(seen[i]), 32'd1);
        check($sformatf("latency_u%0d", i), 32'(lat[i]), 32'(e[7:0]));
        check($sformatf("busy_cycles_u%0d", i), 32'(bcnt[i]), 32'(e[7:0]));
        check($sformatf("eq_lt_gt_u%0d", i), 32'({eq_v[i], lt_v[i], gt_v[i]}), 32'(e[10:8]));
        last_res[i] = e[10:8];
      end
    end
  endtask

  // Start u0/u1, then cancel via abort or reset driven after edge at_j.
  task automatic cancel_run(input logic [31:0] ta, input logic [31:0] tb,
                            input logic use_rst, input int at_j);
    int dcnt [2];
    a_bus   = ta;
    b_bus   = tb;
    sm_bus  = 1'b0;
    start_v = 8'h03;
    @(posedge clk);
    #1;
    start_v = '0;
    dcnt[0] = 0;
    dcnt[1] = 0;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 2; i++) begin
        if (done_v[i]) dcnt[i]++;
      end
      if (j == at_j) begin
        if (use_rst) rst_n = 1'b0;
        else abort_v = 8'h03;
      end
      if (j == at_j + 1) begin
        rst_n   = 1'b1;
        abort_v = '0;
      end
      @(posedge clk);
      #1;
    end
    if (use_rst) begin
      for (int i = 0; i < 8; i++) last_res[i] = 3'b000;
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cancel_no_done_u%0d", i), 32'(dcnt[i]), 32'd0);
      check($sformatf("cancel_busy_u%0d", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("cancel_res_u%0d", i), 32'({eq_v[i], lt_v[i], gt_v[i]}), 32'(last_res[i]));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] ra, rb;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    a_bus    = '0;
    b_bus    = '0;
    sm_bus   = 1'b0;
    start_v  = '0;
    abort_v  = '0;
    for (int i = 0; i < 8; i++) last_res[i] = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("reset_outputs_u%0d", i),
            32'({busy_v[i], done_v[i], eq_v[i], lt_v[i], gt_v[i]}), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // equal operands: full scan on both 16-bit instances
    launch(32'h1234, 32'h1234, 1'b0, 8'h03);
    collect(8'h03, 0);

    // top chunk differs: early exit at start+1, full scan at start+4
    launch(32'h8000, 32'h7FFF, 1'b0, 8'h03);
    collect(8'h03, 0);
    launch(32'h8000, 32'h7FFF, 1'b1, 8'h03);
    collect(8'h03, 0);

    // bottom chunk differs; abort high on the start edge must not block it
    abort_v = 8'h03;
    launch(32'h0001, 32'h0002, 1'b0, 8'h03);
    abort_v = '0;
    collect(8'h03, 0);

    // start held high while busy, then a new start in the done cycle
    launch(32'h1234, 32'h1234, 1'b0, 8'h03);
    collect(8'h03, 3);
    launch(32'h0001, 32'h0002, 1'b0, 8'h03);
    collect(8'h03, 0);

    // abort at start+2, abort on u0's finish edge, reset at start+2
    cancel_run(32'h1234, 32'h1234, 1'b0, 1);
    cancel_run(32'h8000, 32'h7FFF, 1'b0, 0);
    cancel_run(32'h1234, 32'h1234, 1'b1, 1);

    // recovery after reset
    launch(32'hFFFF, 32'h0001, 1'b1, 8'h03);
    collect(8'h03, 0);

    // random operands on every instance
    for (int t = 0; t < 40; t++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: rb = $urandom;
      endcase
      launch(ra, rb, 1'($urandom_range(0, 1)), 8'hFF);
      collect(8'hFF, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
